// File: rtl/act_layer_p.sv
// act_layer_p: frame-wide activation layer. A frame of GROUPS groups, each of
// LANES signed elements, is fed one group per clock through a lane-parallel
// activation stage (bypass, ReLU or table ELU) and collected into q.
// elu_table: per-lane base-2 ELU with a LUT_LAT-deep registered output.

`ifndef ACT_DATA_LEN
`define ACT_DATA_LEN 16
`endif

module elu_table #(
    parameter int DATA_LEN = 16,
    parameter int LUT_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_LEN-1:0] x,
    output logic signed [DATA_LEN-1:0] y
);
    // Fixed point with DATA_LEN/2 fraction bits; negative inputs map to
    // 2^x - 1, where 2^x = 2^n * (1 + f) for x = n + f, 0 <= f < 1.
    localparam int FRAC = DATA_LEN / 2;
    localparam int IW   = DATA_LEN - FRAC;

    function automatic logic signed [DATA_LEN-1:0] elu_f(input logic signed [DATA_LEN-1:0] v);
        logic [IW-1:0]       neg_int;
        logic [DATA_LEN-1:0] mant;
        logic [DATA_LEN-1:0] one;
        logic [DATA_LEN-1:0] r;
        one     = {{(IW-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
        mant    = {{(IW-1){1'b0}}, 1'b1, v[FRAC-1:0]};
        neg_int = -v[DATA_LEN-1:FRAC];
        r       = (mant >> neg_int) - one;
        elu_f   = v[DATA_LEN-1] ? $signed(r) : v;
    endfunction

    logic signed [DATA_LEN-1:0] y_p1 [LUT_LAT];

    // Table output pipeline, LUT_LAT registers deep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_LAT; i++) y_p1[i] <= '0;
        end else begin
            y_p1[0] <= elu_f(x);
            for (int i = 1; i < LUT_LAT; i++) y_p1[i] <= y_p1[i-1];
        end
    end

    assign y = y_p1[LUT_LAT-1];
endmodule

module act_layer_p #(
    parameter int DATA_LEN = `ACT_DATA_LEN,
    parameter int LANES    = 12,
    parameter int GROUPS   = 32,
    parameter int LUT_LAT  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [1:0]                          mode,
    input  logic [GROUPS*LANES*DATA_LEN-1:0]    d,
    output logic                                valid,
    output logic                                busy,
    output logic [GROUPS*LANES*DATA_LEN-1:0]    q
);
    localparam int GW    = LANES * DATA_LEN;
    localparam int IDX_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [1:0]       mode_r;
    logic [IDX_W-1:0] iss_idx, wr_idx, grp_sel;
    logic             issue, wr_en, wr_last;
    logic [GW-1:0]    stage_p0;
    logic             vld_p0;
    logic [GW-1:0]    dly_p1 [LUT_LAT];
    logic             vld_p1 [LUT_LAT];
    logic [GW-1:0]    elu_out, res;

    // Bypass and ReLU path; mode 11 behaves as bypass
    function automatic logic [GW-1:0] pass_f(input logic [GW-1:0] g, input logic [1:0] m);
        logic [DATA_LEN-1:0] e;
        for (int l = 0; l < LANES; l++) begin
            e = g[l*DATA_LEN +: DATA_LEN];
            pass_f[l*DATA_LEN +: DATA_LEN] = (m == 2'b01 && e[DATA_LEN-1]) ? '0 : e;
        end
    endfunction

    assign issue   = load && (state == IDLE || state == FEED);
    assign grp_sel = (state == IDLE) ? '0 : iss_idx;
    assign wr_en   = vld_p1[LUT_LAT-1];
    assign wr_last = wr_en && (wr_idx == LAST_IDX);
    assign res     = (mode_r == 2'b10) ? elu_out : dly_p1[LUT_LAT-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; dropping load returns to IDLE from any state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = FEED;
            FEED:    if (!load) state_nx = IDLE;
                     else if (iss_idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (!load) state_nx = IDLE;
                     else if (wr_last) state_nx = DONE;
            DONE:    if (!load) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == FEED) || (state == DRAIN);
    end

    // valid is registered on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid <= 1'b0;
        else        valid <= (state_nx == DONE);
    end

    // Issue/write counters and the frame's latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_idx <= '0;
            wr_idx  <= '0;
            mode_r  <= 2'b00;
        end else if (state_nx == IDLE) begin
            iss_idx <= '0;
            wr_idx  <= '0;
        end else begin
            if (state == IDLE) begin
                iss_idx <= IDX_W'(1);
                mode_r  <= mode;
            end else if (state == FEED && iss_idx != LAST_IDX) begin
                iss_idx <= iss_idx + 1'b1;
            end
            if (wr_en && wr_idx != LAST_IDX) wr_idx <= wr_idx + 1'b1;
        end
    end

    // Stage register (p0) and matched bypass/ReLU delay line (p1); an abort
    // clears the valid tags so in-flight groups are never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_p0 <= '0;
            vld_p0   <= 1'b0;
            for (int i = 0; i < LUT_LAT; i++) begin
                dly_p1[i] <= '0;
                vld_p1[i] <= 1'b0;
            end
        end else begin
            if (issue) stage_p0 <= d[grp_sel*GW +: GW];
            vld_p0    <= issue;
            dly_p1[0] <= pass_f(stage_p0, mode_r);
            vld_p1[0] <= vld_p0 && load;
            for (int i = 1; i < LUT_LAT; i++) begin
                dly_p1[i] <= dly_p1[i-1];
                vld_p1[i] <= vld_p1[i-1] && load;
            end
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic signed [DATA_LEN-1:0] lane_x;
            logic signed [DATA_LEN-1:0] lane_y;
            assign lane_x = stage_p0[l*DATA_LEN +: DATA_LEN];
            elu_table #(.DATA_LEN(DATA_LEN), .LUT_LAT(LUT_LAT)) u_elu (
                .clk   (clk),
                .rst_n (rst_n),
                .x     (lane_x),
                .y     (lane_y)
            );
            assign elu_out[l*DATA_LEN +: DATA_LEN] = lane_y;
        end
    endgenerate

    // Result storage, one group per write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (wr_en) q[wr_idx*GW +: GW] <= res;
    end
endmodule

// File: tb/tb_act_layer_p.sv
// Testbench for act_layer_p: table vectors, random frames against a
// reference model, and hand-written abort/reset/hold sequences.
module tb_act_layer_p;
    localparam int DL  = 16;
    localparam int LN  = 12;
    localparam int GR  = 32;
    localparam int LL  = 1;
    localparam int GW  = DL * LN;
    localparam int FW  = GW * GR;
    localparam int ONE = 1 << (DL / 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [FW-1:0] d = '0;
    logic          valid, busy;
    logic [FW-1:0] q;

    int n_pass = 0;
    int n_chk  = 0;

    logic [GW-1:0] issued [GR];

    typedef struct {
        logic [1:0]    m;
        logic [DL-1:0] x;
        logic [DL-1:0] y;
    } vec_t;
    vec_t tbl [12];

    act_layer_p #(.DATA_LEN(DL), .LANES(LN), .GROUPS(GR), .LUT_LAT(LL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .mode  (mode),
        .d     (d),
        .valid (valid),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: bypass, ReLU, and ELU as 2^x - 1 with 2^(n+f) = 2^n*(1+f)
    function automatic logic [DL-1:0] ref_elem(input logic [1:0] m, input logic [DL-1:0] x);
        int xi, rem, k, val;
        xi = int'($signed(x));
        if (m == 2'b01) return (xi < 0) ? '0 : x;
        if (m == 2'b10) begin
            if (xi >= 0) return x;
            rem = xi;
            k = 0;
            while (rem < 0) begin
                rem += ONE;
                k++;
            end
            val = ONE + rem;
            for (int i = 0; i < k; i++) val = val / 2;
            return DL'(val - ONE);
        end
        return x;
    endfunction

    function automatic logic [FW-1:0] model_frame(input logic [1:0] m);
        logic [FW-1:0] r;
        for (int g = 0; g < GR; g++)
            for (int l = 0; l < LN; l++)
                r[(g*LN+l)*DL +: DL] = ref_elem(m, issued[g][l*DL +: DL]);
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] r;
        for (int w = 0; w < FW/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_q(input string name, input logic [FW-1:0] exp);
        int bad;
        n_chk++;
        if (q === exp) n_pass++;
        else begin
            bad = 0;
            for (int i = GR*LN-1; i >= 0; i--)
                if (q[i*DL +: DL] !== exp[i*DL +: DL]) bad = i;
            $display("FAIL %s: element %0d got %h expected %h",
                     name, bad, q[bad*DL +: DL], exp[bad*DL +: DL]);
        end
    endtask

    // Runs one frame from IDLE; group g is snapshotted just before edge E_g
    task automatic run_frame(input logic [1:0] m, input bit scramble, input bit switch_mode,
                             output int vedge);
        int busy_bad;
        vedge = -1;
        busy_bad = 0;
        mode = m;
        load = 1'b1;
        for (int e = 0; e < 80; e++) begin
            if (e < GR) issued[e] = d[e*GW +: GW];
            tick();
            if (busy !== ((e <= GR + LL - 1) ? 1'b1 : 1'b0)) busy_bad++;
            if (scramble && e < GR) d = rand_frame();
            if (switch_mode && e == 5) mode = 2'b00;
            if (valid === 1'b1) begin
                vedge = e;
                break;
            end
        end
        check_val("valid_edge", vedge, GR + LL);
        check_val("busy_window", busy_bad, 0);
        check_q("q_frame", model_frame(m));
    endtask

    task automatic end_frame();
        load = 1'b0;
        tick();
        check_val("idle_after_drop", {valid, busy}, 0);
    endtask

    initial begin
        int ve, bad;
        logic [FW-1:0] fa, fb, exp, qs;
        logic [1:0] rm;

        tbl[0]  = '{2'b00, 16'h1234, 16'h1234};
        tbl[1]  = '{2'b00, 16'h8001, 16'h8001};
        tbl[2]  = '{2'b01, 16'h8001, 16'h0000};
        tbl[3]  = '{2'b01, 16'h0005, 16'h0005};
        tbl[4]  = '{2'b01, 16'h7FFF, 16'h7FFF};
        tbl[5]  = '{2'b01, 16'h8000, 16'h0000};
        tbl[6]  = '{2'b10, 16'hFF00, 16'hFF80};
        tbl[7]  = '{2'b10, 16'h0100, 16'h0100};
        tbl[8]  = '{2'b10, 16'hFE80, 16'hFF60};
        tbl[9]  = '{2'b10, 16'h8000, 16'hFF00};
        tbl[10] = '{2'b10, 16'hFFFF, 16'hFFFF};
        tbl[11] = '{2'b11, 16'h8001, 16'h8001};

        // Reset state
        #1;
        check_val("reset_ctrl", {valid, busy}, 0);
        check_val("reset_q_zero", (q === '0) ? 1 : 0, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Bypass with element(g,l) = g*16+l
        for (int g = 0; g < GR; g++)
            for (int l = 0; l < LN; l++)
                d[(g*LN+l)*DL +: DL] = DL'(g*16 + l);
        fa = d;
        run_frame(2'b00, 1'b0, 1'b0, ve);
        check_q("bypass_exact", fa);
        end_frame();

        // ReLU with alternating negative/positive elements
        for (int i = 0; i < GR*LN; i++) d[i*DL +: DL] = (i % 2 == 0) ? 16'h8001 : 16'h0005;
        run_frame(2'b01, 1'b0, 1'b0, ve);
        check_val("relu_neg", q[0 +: DL], 16'h0000);
        check_val("relu_pos", q[DL +: DL], 16'h0005);
        end_frame();

        // ELU with mode switched to bypass at E5
        d = {(GR*LN){16'hFF00}};
        run_frame(2'b10, 1'b0, 1'b1, ve);
        check_val("elu_mode_switch", q[FW-DL +: DL], 16'hFF80);
        end_frame();

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            d = {(GR*LN){tbl[i].x}};
            run_frame(tbl[i].m, 1'b0, 1'b0, ve);
            check_val("tbl_first", q[0 +: DL], tbl[i].y);
            check_val("tbl_last", q[FW-DL +: DL], tbl[i].y);
            end_frame();
        end

        // Random frames, with d changing mid-feed on some
        for (int i = 0; i < 6; i++) begin
            d = rand_frame();
            rm = 2'($urandom_range(0, 3));
            run_frame(rm, i[0], 1'b0, ve);
            end_frame();
        end

        // Abort: load low at E10 keeps groups 0..8 of the new frame
        d = rand_frame();
        run_frame(2'b00, 1'b0, 1'b0, ve);
        end_frame();
        fa = q;
        fb = rand_frame();
        d = fb;
        mode = 2'b00;
        load = 1'b1;
        bad = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        load = 1'b0;
        tick();
        check_val("abort_ctrl", {valid, busy}, 0);
        for (int g = 0; g < GR; g++)
            exp[g*GW +: GW] = (g <= 8) ? fb[g*GW +: GW] : fa[g*GW +: GW];
        check_q("abort_q", exp);
        for (int e = 0; e < 5; e++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        check_val("abort_no_valid", bad, 0);
        check_q("abort_q_stable", exp);

        // Reset pulsed mid-frame just before E20
        d = rand_frame();
        mode = 2'b01;
        load = 1'b1;
        for (int e = 0; e < 20; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_ctrl", {valid, busy}, 0);
        check_val("rst_async_q", (q === '0) ? 1 : 0, 1);
        load = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check_val("rst_after_release", {valid, busy, (q === '0) ? 1'b1 : 1'b0}, 1);
        d = rand_frame();
        run_frame(2'b10, 1'b0, 1'b0, ve);

        // Hold load high 50 edges past valid; no restart
        qs = q;
        d = rand_frame();
        bad = 0;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (valid !== 1'b1 || busy !== 1'b0 || q !== qs) bad++;
        end
        check_val("hold_stable", bad, 0);
        end_frame();
        d = rand_frame();
        run_frame(2'b01, 1'b0, 1'b0, ve);
        end_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
